// File: rtl/nios_sysid_pkg.sv
// nios_sysid_pkg: shared constants and helpers for the nios_sysid_ext register slave.
//   - Word offsets of every register in the map.
//   - Bit positions inside the CTRL register.
//   - apply_be(): merges a write word into an old word under a byte-enable mask.
package nios_sysid_pkg;

  localparam int unsigned REG_ID        = 0;
  localparam int unsigned REG_TIMESTAMP = 1;
  localparam int unsigned REG_UPTIME_LO = 2;
  localparam int unsigned REG_UPTIME_HI = 3;
  localparam int unsigned REG_CTRL      = 4;
  localparam int unsigned REG_PRESCALE  = 5;
  localparam int unsigned REG_SCRATCH0  = 6;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_CLR     = 1;
  localparam int unsigned CTRL_WRAPPED = 2;

  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nios_sysid_uptime.sv
// nios_sysid_uptime: prescaled free-running 64-bit uptime counter.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_en               count enable (freezes prescaler and counter when low)
//   i_prescale         counter ticks every i_prescale+1 enabled clocks
//   i_clr              clears counter, prescaler and wrapped flag (wins over a tick)
//   i_lo_rd            UPTIME_LO read accepted: snapshot the pre-increment high word
//   o_cnt_lo           counter bits [31:0]
//   o_hi_shadow        high word captured by the last UPTIME_LO read
//   o_wrapped          sticky flag, set when the counter rolls over from all-ones
module nios_sysid_uptime (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [31:0] i_prescale,
  input  logic        i_clr,
  input  logic        i_lo_rd,
  output logic [31:0] o_cnt_lo,
  output logic [31:0] o_hi_shadow,
  output logic        o_wrapped
);

  logic [31:0] r_pre_cnt;
  logic [31:0] w_pre_cnt_d;
  logic [63:0] r_cnt;
  logic [63:0] w_cnt_d;
  logic        r_wrapped;
  logic        w_wrapped_d;
  logic [31:0] r_hi_shadow;
  logic        w_tick;

  always_comb begin
    w_tick      = 1'b0;
    w_pre_cnt_d = r_pre_cnt;
    w_cnt_d     = r_cnt;
    w_wrapped_d = r_wrapped;
    if (i_en) begin
      // A PRESCALE write below the current count restarts the prescaler without a tick.
      if (r_pre_cnt > i_prescale) begin
        w_pre_cnt_d = '0;
      end else if (r_pre_cnt == i_prescale) begin
        w_pre_cnt_d = '0;
        w_tick      = 1'b1;
      end else begin
        w_pre_cnt_d = r_pre_cnt + 32'd1;
      end
    end
    if (w_tick) begin
      w_cnt_d = r_cnt + 64'd1;
      if (&r_cnt) w_wrapped_d = 1'b1;
    end
    if (i_clr) begin
      w_pre_cnt_d = '0;
      w_cnt_d     = '0;
      w_wrapped_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pre_cnt   <= '0;
      r_cnt       <= '0;
      r_wrapped   <= 1'b0;
      r_hi_shadow <= '0;
    end else begin
      r_pre_cnt <= w_pre_cnt_d;
      r_cnt     <= w_cnt_d;
      r_wrapped <= w_wrapped_d;
      // Captured from the pre-edge count so hi/lo form one consistent snapshot.
      if (i_lo_rd) r_hi_shadow <= r_cnt[63:32];
    end
  end

  assign o_cnt_lo    = r_cnt[31:0];
  assign o_hi_shadow = r_hi_shadow;
  assign o_wrapped   = r_wrapped;

endmodule

// File: rtl/nios_sysid_ext.sv
// nios_sysid_ext: Avalon-MM system ID slave with uptime counter, control and scratch words.
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_address            word address
//   i_read, i_write      one-cycle transfer requests (read wins when both are high)
//   i_writedata          write data
//   i_byteenable         byte lanes for writes
//   o_readdata           registered read data, holds between reads
//   o_readdatavalid      one-cycle strobe, one clock after an accepted read
module nios_sysid_ext
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE         = 32'd591751049,
  parameter logic [31:0] TIMESTAMP        = 32'd1603466045,
  parameter int unsigned NUM_SCRATCH      = 4,
  parameter logic [31:0] PRESCALE_DEFAULT = 32'd49,
  parameter int unsigned ADDR_W           = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_writedata,
  input  logic [3:0]        i_byteenable,
  output logic [31:0]       o_readdata,
  output logic              o_readdatavalid
);

  logic [31:0] w_addr;
  logic        w_wr;
  logic        w_clr;
  logic        w_lo_rd;
  logic [31:0] w_cnt_lo;
  logic [31:0] w_hi_shadow;
  logic        w_wrapped;
  logic [31:0] w_rdata;

  logic        r_en;
  logic [31:0] r_prescale;
  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] r_rdata;
  logic        r_rdatavalid;

  assign w_addr  = 32'(i_address);
  // A simultaneous read drops the write.
  assign w_wr    = i_write & ~i_read;
  assign w_clr   = w_wr && (w_addr == REG_CTRL) && i_byteenable[0] && i_writedata[CTRL_CLR];
  assign w_lo_rd = i_read && (w_addr == REG_UPTIME_LO);

  nios_sysid_uptime u_uptime (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_en        (r_en),
    .i_prescale  (r_prescale),
    .i_clr       (w_clr),
    .i_lo_rd     (w_lo_rd),
    .o_cnt_lo    (w_cnt_lo),
    .o_hi_shadow (w_hi_shadow),
    .o_wrapped   (w_wrapped)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_en       <= 1'b1;
      r_prescale <= PRESCALE_DEFAULT;
    end else if (w_wr) begin
      if (w_addr == REG_CTRL && i_byteenable[0]) r_en <= i_writedata[CTRL_EN];
      if (w_addr == REG_PRESCALE) r_prescale <= apply_be(r_prescale, i_writedata, i_byteenable);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr && w_addr == REG_SCRATCH0 + i) begin
          r_scratch[i] <= apply_be(r_scratch[i], i_writedata, i_byteenable);
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      REG_ID:        w_rdata = ID_VALUE;
      REG_TIMESTAMP: w_rdata = TIMESTAMP;
      REG_UPTIME_LO: w_rdata = w_cnt_lo;
      REG_UPTIME_HI: w_rdata = w_hi_shadow;
      REG_CTRL: begin
        w_rdata[CTRL_EN]      = r_en;
        w_rdata[CTRL_WRAPPED] = w_wrapped;
      end
      REG_PRESCALE:  w_rdata = r_prescale;
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (w_addr == REG_SCRATCH0 + i) w_rdata = r_scratch[i];
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rdata      <= '0;
      r_rdatavalid <= 1'b0;
    end else begin
      r_rdatavalid <= i_read;
      if (i_read) r_rdata <= w_rdata;
    end
  end

  assign o_readdata      = r_rdata;
  assign o_readdatavalid = r_rdatavalid;

endmodule

// File: doc/nios_sysid_ext.md
Name: nios_sysid_ext

Overview:
Parametrised successor to the fixed two-word system ID slave. Avalon-MM slave on the Nios II control bus that returns:
- the build ID and timestamp constants;
- a free-running, prescaled 64-bit uptime counter with atomic hi/lo snapshot;
- a control/prescale register;
- NUM_SCRATCH byte-writable scratch words used by software for boot handshakes.

Reads are registered, with a readdatavalid strobe.

Parameters:
ID_VALUE, 32'd591751049, system ID word (register 0)
TIMESTAMP, 32'd1603466045, build timestamp (register 1)
NUM_SCRATCH, 4, number of scratch registers, 1..16
PRESCALE_DEFAULT, 32'd49, reset value of PRESCALE; uptime ticks every PRESCALE+1 clocks
ADDR_W, 4, word-address width; must satisfy 2^ADDR_W >= 6+NUM_SCRATCH

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  word address
read  in  1  read request, one cycle per transfer
write  in  1  write request, one cycle per transfer
writedata  in  32  write data
byteenable  in  4  byte lanes for writes
readdata  out  32  registered read data
readdatavalid  out  1  high exactly one cycle, one clock after an accepted read

Behaviour:
Register map (word addresses):
- 0 ID: read-only.
- 1 TIMESTAMP: read-only.
- 2 UPTIME_LO: read-only. A read returns cnt[31:0] and, in the same edge, latches cnt[63:32] into hi_shadow.
- 3 UPTIME_HI: read-only. Returns hi_shadow.
- 4 CTRL:
  - bit0 EN: R/W, reset 1.
  - bit1 CLR: write-1 pulse, reads 0.
  - bit2 WRAPPED: sticky, read-only; set when cnt wraps from all-ones to 0; cleared by CLR.
- 5 PRESCALE: R/W, byteenable honoured, reset PRESCALE_DEFAULT.
- 6..6+NUM_SCRATCH-1 SCRATCHn: R/W, byteenable honoured, reset 0.

Other addresses: reads return 0; writes are ignored. Writes to read-only registers are ignored.

Interface:
- No waitrequest; every transfer is accepted in its cycle.
- Read latency is exactly 1: readdata and readdatavalid update on the edge after read=1.
- readdata holds its last value when no read is pending. readdatavalid is 0 otherwise.
- read and write both high in one cycle: the read is performed and the write is dropped.
- Back-to-back reads every cycle give readdatavalid high every cycle.

Prescaler and counter:
- pre_cnt counts 0..PRESCALE. At PRESCALE with EN=1, pre_cnt returns to 0 and a tick is issued; cnt increments by 1 (mod 2^64).
- EN=0 freezes both pre_cnt and cnt.
- PRESCALE=0 ticks every cycle.
- A PRESCALE write takes effect immediately. If pre_cnt > new PRESCALE, pre_cnt restarts at 0 on the next cycle with no tick.
- CLR write: cnt, pre_cnt and WRAPPED go to 0 on that edge. CLR wins over a simultaneous tick. EN is written by the same access.
- Wrap from 64'hFFFF_FFFF_FFFF_FFFF: cnt goes to 0 and WRAPPED is set. A CLR in the same cycle wins, leaving WRAPPED=0.
- UPTIME_LO read in a tick cycle: returns the pre-increment value, and hi_shadow latches the pre-increment hi.

Reset (asynchronous, any time, including mid-read):
- readdata=0, readdatavalid=0.
- cnt=0, pre_cnt=0, hi_shadow=0.
- EN=1, WRAPPED=0, PRESCALE=PRESCALE_DEFAULT, scratch=0.
- A read in flight is lost; no readdatavalid is issued for it.

Decomposition:
- Package nios_sysid_pkg: register offset constants (REG_ID..REG_SCRATCH0), CTRL bit indices, and a function applying byteenable to a 32-bit word.
- One sub-module, nios_sysid_uptime: prescaler, 64-bit counter, WRAPPED and hi_shadow.
- Top level holds address decode, scratch array and the read pipeline register.

Test Plan:
1. Release reset, read addr 0 then addr 1 back-to-back -> readdatavalid high on two consecutive cycles; data 591751049 then 1603466045; CTRL reads 0x1, PRESCALE reads 49.
2. Write PRESCALE=0, wait 10 cycles, read UPTIME_LO then UPTIME_HI -> LO equals cycles elapsed since the write (±1 per spec edge); HI reads 0; a second HI read returns the same shadow.
3. Write SCRATCH2=0xA5A5A5A5 with byteenable=4'b0101 after reset -> readback 0x00A500A5; SCRATCH0 and SCRATCH1 unchanged at 0.
4. Write CTRL=0x0 (EN=0), wait 100 cycles -> two UPTIME_LO reads are identical. Write CTRL=0x3 -> next LO read is a small value (< PRESCALE+3 ticks after clear).
5. Force cnt to 64'hFFFF_FFFF_FFFF_FFFF via hierarchical preload, PRESCALE=0 -> after one tick, UPTIME_LO=0, UPTIME_HI=0, CTRL bit2=1. Write CLR -> bit2=0.
6. Assert reset during a cycle with read=1 -> no readdatavalid follows; all registers read back at reset values; simultaneous read+write to SCRATCH0 returns the old value and the write is not applied.
